// File: rtl/cascade_counter_bank.sv
// ---------------------------------------------------------------------------
// cascade_counter_bank
//   NUM_CH counters of WIDTH bits, each with its own terminal-count register.
//   In independent mode (mode_i=0) every channel steps on en_i. In cascade
//   mode (mode_i=1) channel i steps only in the cycle that channel i-1 wraps.
//   Per channel it produces a one-cycle wrap pulse and a toggle-divided
//   "overflow clock". Used as the baud/bit-timing tick generator.
//
// Ports
//   clk_i         system clock, rising edge
//   rst_ni        asynchronous active-low reset
//   en_i          count enable (channel 0, and all channels when independent)
//   clr_i         synchronous clear of counts and overflow outputs (tc kept)
//   mode_i        0 = independent, 1 = cascade
//   tc_load_i     terminal-count write strobe
//   tc_sel_i      channel index for the write (>= NUM_CH is ignored)
//   tc_data_i     terminal-count value to write
//   count_flat_o  counts, channel i at [i*WIDTH +: WIDTH]
//   ovf_pulse_o   registered one-cycle wrap pulse per channel
//   ovf_clk_o     per-channel toggle on every wrap
//   all_ovf_o     registered pulse when all channels wrap together
//   ovf_sticky_o  sticky wrap flags
//
// Build option
//   CASCADE_COUNTER_STICKY_EN : when defined, ovf_sticky_o holds a flag per
//   channel that sets on wrap and clears on clr_i or reset. When undefined
//   the output is tied to zero.
// ---------------------------------------------------------------------------
module cascade_counter_bank #(
    parameter int NUM_CH = 2,
    parameter int WIDTH  = 8,
    parameter int SEL_W  = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    en_i,
    input  logic                    clr_i,
    input  logic                    mode_i,
    input  logic                    tc_load_i,
    input  logic [SEL_W-1:0]        tc_sel_i,
    input  logic [WIDTH-1:0]        tc_data_i,
    output logic [NUM_CH*WIDTH-1:0] count_flat_o,
    output logic [NUM_CH-1:0]       ovf_pulse_o,
    output logic [NUM_CH-1:0]       ovf_clk_o,
    output logic                    all_ovf_o,
    output logic [NUM_CH-1:0]       ovf_sticky_o
);

    logic [WIDTH-1:0]  cnt_q [NUM_CH];
    logic [WIDTH-1:0]  cnt_d [NUM_CH];
    logic [WIDTH-1:0]  tc_q  [NUM_CH];
    logic [WIDTH-1:0]  tc_d  [NUM_CH];
    logic [NUM_CH-1:0] ovf_pulse_q, ovf_pulse_d;
    logic [NUM_CH-1:0] ovf_clk_q, ovf_clk_d;
    logic              all_ovf_q, all_ovf_d;
    logic [NUM_CH-1:0] wrap;

    // The cascade ripples combinationally through all channels within one
    // cycle; a single sequential loop keeps the chain inside one process.
    always_comb begin
        logic step;
        logic carry;
        step  = 1'b0;
        carry = 1'b0;
        wrap  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            step    = (i == 0 || !mode_i) ? en_i : carry;
            // >= so a tc lowered below the current count still wraps
            wrap[i] = step && (cnt_q[i] >= tc_q[i]);
            carry   = wrap[i];

            if (clr_i || wrap[i]) begin
                cnt_d[i] = '0;
            end else if (step) begin
                cnt_d[i] = cnt_q[i] + WIDTH'(1);
            end else begin
                cnt_d[i] = cnt_q[i];
            end

            if (tc_load_i && (int'(tc_sel_i) == i)) begin
                tc_d[i] = tc_data_i;
            end else begin
                tc_d[i] = tc_q[i];
            end
        end

        ovf_pulse_d = clr_i ? '0 : wrap;
        ovf_clk_d   = clr_i ? '0 : (ovf_clk_q ^ wrap);
        all_ovf_d   = (&wrap) && !clr_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
                tc_q[i]  <= '1;
            end
            ovf_pulse_q <= '0;
            ovf_clk_q   <= '0;
            all_ovf_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
                tc_q[i]  <= tc_d[i];
            end
            ovf_pulse_q <= ovf_pulse_d;
            ovf_clk_q   <= ovf_clk_d;
            all_ovf_q   <= all_ovf_d;
        end
    end

`ifdef CASCADE_COUNTER_STICKY_EN
    logic [NUM_CH-1:0] sticky_q, sticky_d;

    // clr beats a same-cycle wrap
    always_comb begin
        sticky_d = clr_i ? '0 : (sticky_q | wrap);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign ovf_sticky_o = sticky_q;
`else
    assign ovf_sticky_o = '0;
`endif

    always_comb begin
        count_flat_o = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            count_flat_o[i*WIDTH +: WIDTH] = cnt_q[i];
        end
    end

    assign ovf_pulse_o = ovf_pulse_q;
    assign ovf_clk_o   = ovf_clk_q;
    assign all_ovf_o   = all_ovf_q;

endmodule

// File: tb/tb_cascade_counter_bank.sv
module tb_cascade_counter_bank;

    localparam int NUM_CH = 2;
    localparam int WIDTH  = 4;
    localparam int SEL_W  = 3;
`ifdef CASCADE_COUNTER_STICKY_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic                    clk_i;
    logic                    rst_ni;
    logic                    en_i;
    logic                    clr_i;
    logic                    mode_i;
    logic                    tc_load_i;
    logic [SEL_W-1:0]        tc_sel_i;
    logic [WIDTH-1:0]        tc_data_i;
    logic [NUM_CH*WIDTH-1:0] count_flat_o;
    logic [NUM_CH-1:0]       ovf_pulse_o;
    logic [NUM_CH-1:0]       ovf_clk_o;
    logic                    all_ovf_o;
    logic [NUM_CH-1:0]       ovf_sticky_o;

    int nvec = 0;
    int nerr = 0;

    cascade_counter_bank #(
        .NUM_CH(NUM_CH),
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .en_i        (en_i),
        .clr_i       (clr_i),
        .mode_i      (mode_i),
        .tc_load_i   (tc_load_i),
        .tc_sel_i    (tc_sel_i),
        .tc_data_i   (tc_data_i),
        .count_flat_o(count_flat_o),
        .ovf_pulse_o (ovf_pulse_o),
        .ovf_clk_o   (ovf_clk_o),
        .all_ovf_o   (all_ovf_o),
        .ovf_sticky_o(ovf_sticky_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got %0d vectors, want completion", nvec);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_in();
        en_i      = 1'b0;
        clr_i     = 1'b0;
        tc_load_i = 1'b0;
        tc_sel_i  = '0;
        tc_data_i = '0;
    endtask

    // one clocked cycle with clr and a tc write, enable low
    task automatic clr_load(input logic [SEL_W-1:0] sel, input logic [WIDTH-1:0] data);
        idle_in();
        clr_i     = 1'b1;
        tc_load_i = 1'b1;
        tc_sel_i  = sel;
        tc_data_i = data;
        tick();
        idle_in();
    endtask

    initial begin
        rst_ni = 1'b0;
        mode_i = 1'b0;
        idle_in();
        #2;
        chk("rst_cnt", 32'(count_flat_o), 32'h0);
        chk("rst_pulse", 32'(ovf_pulse_o), 32'h0);
        chk("rst_oclk", 32'(ovf_clk_o), 32'h0);
        chk("rst_all", 32'(all_ovf_o), 32'h0);
        chk("rst_stk", 32'(ovf_sticky_o), 32'h0);

        // independent, default tc=15
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        en_i   = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("t1_cnt0_k%0d", k), 32'(count_flat_o[3:0]), 32'(k % 16));
            chk($sformatf("t1_cnt1_k%0d", k), 32'(count_flat_o[7:4]), 32'(k % 16));
            chk($sformatf("t1_pulse_k%0d", k), 32'(ovf_pulse_o), (k == 16) ? 32'h3 : 32'h0);
            chk($sformatf("t1_all_k%0d", k), 32'(all_ovf_o), (k == 16) ? 32'h1 : 32'h0);
            chk($sformatf("t1_oclk_k%0d", k), 32'(ovf_clk_o), (k == 16) ? 32'h3 : 32'h0);
        end
        chk("t1_stk", 32'(ovf_sticky_o), STK ? 32'h3 : 32'h0);

        // cascade, tc0=2 tc1=3
        clr_load(3'd0, 4'd2);
        chk("t2_clr_oclk", 32'(ovf_clk_o), 32'h0);
        chk("t2_clr_stk", 32'(ovf_sticky_o), 32'h0);
        clr_load(3'd1, 4'd3);
        mode_i = 1'b1;
        en_i   = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("t2_cnt0_k%0d", k), 32'(count_flat_o[3:0]), 32'(k % 3));
            chk($sformatf("t2_cnt1_k%0d", k), 32'(count_flat_o[7:4]), 32'((k / 3) % 4));
            chk($sformatf("t2_p0_k%0d", k), 32'(ovf_pulse_o[0]), (k % 3 == 0) ? 32'h1 : 32'h0);
            chk($sformatf("t2_all_k%0d", k), 32'(all_ovf_o), (k == 12) ? 32'h1 : 32'h0);
        end

        // tc0=0, independent: continuous pulse on ch0, ch1 (tc=3) counts
        mode_i = 1'b0;
        clr_load(3'd0, 4'd0);
        en_i = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("t3_p0_k%0d", k), 32'(ovf_pulse_o[0]), 32'h1);
            chk($sformatf("t3_oclk0_k%0d", k), 32'(ovf_clk_o[0]), 32'(k % 2));
            chk($sformatf("t3_cnt1_k%0d", k), 32'(count_flat_o[7:4]), 32'(k));
        end
        en_i = 1'b0;
        tick();
        chk("t3_hold_p0", 32'(ovf_pulse_o[0]), 32'h0);
        chk("t3_hold_cnt1", 32'(count_flat_o[7:4]), 32'h3);
        chk("t3_hold_oclk0", 32'(ovf_clk_o[0]), 32'h1);

        // lower tc below count: 10 -> tc 5
        clr_load(3'd0, 4'd15);
        en_i = 1'b1;
        for (int k = 1; k <= 10; k++) tick();
        chk("t4_cnt0_10", 32'(count_flat_o[3:0]), 32'd10);
        en_i      = 1'b0;
        tc_load_i = 1'b1;
        tc_sel_i  = 3'd0;
        tc_data_i = 4'd5;
        tick();
        idle_in();
        chk("t4_hold10", 32'(count_flat_o[3:0]), 32'd10);
        en_i = 1'b1;
        tick();
        chk("t4_wrap_cnt0", 32'(count_flat_o[3:0]), 32'd0);
        chk("t4_wrap_p0", 32'(ovf_pulse_o[0]), 32'h1);
        tick();
        chk("t4_after_cnt0", 32'(count_flat_o[3:0]), 32'd1);
        chk("t4_after_p0", 32'(ovf_pulse_o[0]), 32'h0);

        // same-cycle load uses old tc: tc 15 -> 3 while cnt0=3
        clr_load(3'd0, 4'd15);
        en_i = 1'b1;
        for (int k = 1; k <= 3; k++) tick();
        chk("t4b_cnt0_3", 32'(count_flat_o[3:0]), 32'd3);
        tc_load_i = 1'b1;
        tc_sel_i  = 3'd0;
        tc_data_i = 4'd3;
        tick();
        tc_load_i = 1'b0;
        chk("t4b_oldtc_cnt0", 32'(count_flat_o[3:0]), 32'd4);
        chk("t4b_oldtc_p0", 32'(ovf_pulse_o[0]), 32'h0);
        tick();
        chk("t4b_newtc_cnt0", 32'(count_flat_o[3:0]), 32'd0);
        chk("t4b_newtc_p0", 32'(ovf_pulse_o[0]), 32'h1);

        // clr with en and tc_load(sel=1,data=7); then sel=3 write ignored
        tick();
        tick();
        clr_i     = 1'b1;
        en_i      = 1'b1;
        tc_load_i = 1'b1;
        tc_sel_i  = 3'd1;
        tc_data_i = 4'd7;
        tick();
        idle_in();
        chk("t5_clr_cnt", 32'(count_flat_o), 32'h0);
        chk("t5_clr_pulse", 32'(ovf_pulse_o), 32'h0);
        chk("t5_clr_oclk", 32'(ovf_clk_o), 32'h0);
        chk("t5_clr_all", 32'(all_ovf_o), 32'h0);
        chk("t5_clr_stk", 32'(ovf_sticky_o), 32'h0);
        tc_load_i = 1'b1;
        tc_sel_i  = 3'd3;
        tc_data_i = 4'd1;
        tick();
        idle_in();
        en_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("t5_cnt1_k%0d", k), 32'(count_flat_o[7:4]), 32'(k % 8));
            chk($sformatf("t5_p1_k%0d", k), 32'(ovf_pulse_o[1]), (k == 8) ? 32'h1 : 32'h0);
        end
        chk("t5_stk", 32'(ovf_sticky_o), STK ? 32'h3 : 32'h0);

        // async reset between edges; tc returns to 15
        @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_cnt", 32'(count_flat_o), 32'h0);
        chk("t6_rst_pulse", 32'(ovf_pulse_o), 32'h0);
        chk("t6_rst_oclk", 32'(ovf_clk_o), 32'h0);
        chk("t6_rst_stk", 32'(ovf_sticky_o), 32'h0);
        #2;
        rst_ni = 1'b1;
        en_i   = 1'b1;
        mode_i = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 4 || k == 8 || k == 15 || k == 16) begin
                chk($sformatf("t6_cnt0_k%0d", k), 32'(count_flat_o[3:0]), 32'(k % 16));
                chk($sformatf("t6_cnt1_k%0d", k), 32'(count_flat_o[7:4]), 32'(k % 16));
                chk($sformatf("t6_pulse_k%0d", k), 32'(ovf_pulse_o), (k == 16) ? 32'h3 : 32'h0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
